multi_phase_traffic_controller: RTL

//  Parametrised successor to the single-intersection traffic controller. Sequences NUM_PHASES approach

---
 rtl/multi_phase_traffic_controller_pkg.sv | 30 +++
 rtl/multi_phase_traffic_controller_if.sv | 43 ++++
 rtl/multi_phase_traffic_controller_timer.sv | 80 ++++++++
 rtl/multi_phase_traffic_controller.sv | 224 ++++++++++++++++++++++
 4 files changed

// File: rtl/multi_phase_traffic_controller_pkg.sv
// ----------------------------------------------------------------------------
// multi_phase_traffic_controller_pkg
// Shared types and constants for the multi-phase traffic controller:
//   state_e          controller state encoding
//   LAMP_*           bit offsets of the four lamps inside one phase nibble
//   MAX_PHASES       largest supported number of approach phases
//   PHASE_W          width of a phase index (sized for MAX_PHASES)
// No ports (package).
// ----------------------------------------------------------------------------
package multi_phase_traffic_controller_pkg;

    typedef enum logic [2:0] {
        S_ALL_RED  = 3'd0,
        S_LEFT_ADV = 3'd1,
        S_GREEN    = 3'd2,
        S_WALK     = 3'd3,
        S_FDW      = 3'd4,
        S_AMBER    = 3'd5
    } state_e;

    localparam int LAMP_RED        = 0;
    localparam int LAMP_AMBER      = 1;
    localparam int LAMP_GREEN      = 2;
    localparam int LAMP_ARROW      = 3;
    localparam int LAMPS_PER_PHASE = 4;

    localparam int MAX_PHASES = 4;
    localparam int PHASE_W    = $clog2(MAX_PHASES);

endpackage

// File: rtl/multi_phase_traffic_controller_if.sv
// ----------------------------------------------------------------------------
// multi_phase_traffic_controller_if
// Bundles the controller's request inputs and lamp/status outputs.
//   debug                 1 = fast tick rate
//   not_walk_request      active-low pedestrian buttons, one per phase
//   not_left_request      active-low phase-0 left-turn request
//   lamp                  per phase p: [4p+3] arrow, [4p+2] green, [4p+1] amber, [4p] red
//   walk_on               walk symbol lit, per phase
//   dont_walk_on          don't-walk symbol lit, per phase (blinks in FDW)
//   active_phase          phase owning right-of-way
//   seconds_left          seconds remaining in the current interval
//   walk_request_waiting  OR of latched, unserved walk requests
// master drives the requests (board / bench); slave is the controller.
// ----------------------------------------------------------------------------
interface multi_phase_traffic_controller_if #(
    parameter int NUM_PHASES = 2,
    parameter int TW         = 8
);
    import multi_phase_traffic_controller_pkg::*;

    logic                                  debug;
    logic [NUM_PHASES-1:0]                 not_walk_request;
    logic                                  not_left_request;
    logic [LAMPS_PER_PHASE*NUM_PHASES-1:0] lamp;
    logic [NUM_PHASES-1:0]                 walk_on;
    logic [NUM_PHASES-1:0]                 dont_walk_on;
    logic [PHASE_W-1:0]                    active_phase;
    logic [TW-1:0]                         seconds_left;
    logic                                  walk_request_waiting;

    modport master (
        output debug, not_walk_request, not_left_request,
        input  lamp, walk_on, dont_walk_on, active_phase, seconds_left,
               walk_request_waiting
    );

    modport slave (
        input  debug, not_walk_request, not_left_request,
        output lamp, walk_on, dont_walk_on, active_phase, seconds_left,
               walk_request_waiting
    );

endinterface

// File: rtl/multi_phase_traffic_controller_timer.sv
// ----------------------------------------------------------------------------
// multi_phase_traffic_controller_timer
// Interval timer: a prescaler producing a one-cycle tick every N clocks
// (N selected by debug_i) and a seconds countdown that is reloaded by the
// controller and decremented on every tick.
//   clk_i       clock
//   rst_ni      async active-low reset
//   debug_i     synchronised debug select; a change restarts the prescaler
//   load_i      load load_val_i into the countdown this cycle
//   load_val_i  duration of the interval being entered
//   expire_o    tick while the countdown reads 1 (last tick of the interval)
//   secs_o      registered countdown value
//   secs_d_o    value the countdown takes at the next clock edge
// ----------------------------------------------------------------------------
module multi_phase_traffic_controller_timer #(
    parameter int TICK_CYCLES       = 27_000_000,
    parameter int DEBUG_TICK_CYCLES = 2_700_000,
    parameter int TW                = 8,
    parameter int RESET_S           = 2
) (
    input  logic          clk_i,
    input  logic          rst_ni,
    input  logic          debug_i,
    input  logic          load_i,
    input  logic [TW-1:0] load_val_i,
    output logic          expire_o,
    output logic [TW-1:0] secs_o,
    output logic [TW-1:0] secs_d_o
);

    localparam int PMAX = (TICK_CYCLES > DEBUG_TICK_CYCLES) ? TICK_CYCLES : DEBUG_TICK_CYCLES;
    localparam int PW   = (PMAX > 2) ? $clog2(PMAX) : 1;
    localparam logic [PW-1:0] LAST_NORM  = PW'(TICK_CYCLES - 1);
    localparam logic [PW-1:0] LAST_DEBUG = PW'(DEBUG_TICK_CYCLES - 1);

    logic [PW-1:0] presc_q, presc_d;
    logic          debug_q;
    logic          mode_change;
    logic          tick;
    logic [TW-1:0] secs_q, secs_d;

    always_comb begin
        mode_change = (debug_i != debug_q);
        // No tick on the cycle the rate changes: the count belongs to the old rate.
        tick = !mode_change && (presc_q == (debug_i ? LAST_DEBUG : LAST_NORM));

        if (mode_change || tick) begin
            presc_d = '0;
        end else begin
            presc_d = presc_q + 1'b1;
        end

        // The controller always reloads on expiry, so the floor at 1 only
        // guards against an unserved expiry.
        if (load_i) begin
            secs_d = load_val_i;
        end else if (tick && (secs_q > TW'(1))) begin
            secs_d = secs_q - 1'b1;
        end else begin
            secs_d = secs_q;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            presc_q <= '0;
            debug_q <= 1'b0;
            secs_q  <= TW'(RESET_S);
        end else begin
            presc_q <= presc_d;
            debug_q <= debug_i;
            secs_q  <= secs_d;
        end
    end

    assign expire_o = tick && (secs_q == TW'(1));
    assign secs_o   = secs_q;
    assign secs_d_o = secs_d;

endmodule

// File: rtl/multi_phase_traffic_controller.sv
// ----------------------------------------------------------------------------
// multi_phase_traffic_controller
// Serves NUM_PHASES approach phases round-robin (green / amber / all-red),
// latches pedestrian walk requests per phase and an optional protected
// left-turn advance on phase 0. All outputs are registered.
//   clk_27     system clock
//   not_reset  async active-low reset
//   bus        slave side of multi_phase_traffic_controller_if:
//              debug, not_walk_request, not_left_request in;
//              lamp, walk_on, dont_walk_on, active_phase, seconds_left,
//              walk_request_waiting out
// ----------------------------------------------------------------------------
module multi_phase_traffic_controller
    import multi_phase_traffic_controller_pkg::*;
#(
    parameter int NUM_PHASES        = 2,
    parameter int TICK_CYCLES       = 27_000_000,
    parameter int DEBUG_TICK_CYCLES = 2_700_000,
    parameter int GREEN_S           = 20,
    parameter int WALK_S            = 10,
    parameter int FDW_S             = 6,
    parameter int AMBER_S           = 4,
    parameter int ALL_RED_S         = 2,
    parameter int LEFT_S            = 6,
    parameter int TW                = 8
) (
    input  logic clk_27,
    input  logic not_reset,
    multi_phase_traffic_controller_if.slave bus
);

    localparam int LW = LAMPS_PER_PHASE * NUM_PHASES;

    // ---------------- input synchronisers ----------------
    logic [NUM_PHASES-1:0] walk_s1_q, walk_s2_q;
    logic                  left_s1_q, left_s2_q;
    logic                  dbg_s1_q,  dbg_s2_q;

    always_ff @(posedge clk_27 or negedge not_reset) begin
        if (!not_reset) begin
            walk_s1_q <= '1;
            walk_s2_q <= '1;
            left_s1_q <= 1'b1;
            left_s2_q <= 1'b1;
            dbg_s1_q  <= 1'b0;
            dbg_s2_q  <= 1'b0;
        end else begin
            walk_s1_q <= bus.not_walk_request;
            walk_s2_q <= walk_s1_q;
            left_s1_q <= bus.not_left_request;
            left_s2_q <= left_s1_q;
            dbg_s1_q  <= bus.debug;
            dbg_s2_q  <= dbg_s1_q;
        end
    end

    // ---------------- interval timer ----------------
    logic          expire;
    logic          load;
    logic [TW-1:0] load_val;
    logic [TW-1:0] secs_q;
    logic [TW-1:0] secs_d;

    multi_phase_traffic_controller_timer #(
        .TICK_CYCLES      (TICK_CYCLES),
        .DEBUG_TICK_CYCLES(DEBUG_TICK_CYCLES),
        .TW               (TW),
        .RESET_S          (ALL_RED_S)
    ) u_timer (
        .clk_i     (clk_27),
        .rst_ni    (not_reset),
        .debug_i   (dbg_s2_q),
        .load_i    (load),
        .load_val_i(load_val),
        .expire_o  (expire),
        .secs_o    (secs_q),
        .secs_d_o  (secs_d)
    );

    // ---------------- helpers ----------------
    function automatic logic [TW-1:0] duration(input state_e s);
        case (s)
            S_LEFT_ADV: duration = TW'(LEFT_S);
            S_GREEN:    duration = TW'(GREEN_S);
            S_WALK:     duration = TW'(WALK_S);
            S_FDW:      duration = TW'(FDW_S);
            S_AMBER:    duration = TW'(AMBER_S);
            default:    duration = TW'(ALL_RED_S);
        endcase
    endfunction

    function automatic logic walk_latched(input logic [NUM_PHASES-1:0] lat,
                                          input logic [PHASE_W-1:0]    p);
        walk_latched = 1'b0;
        for (int i = 0; i < NUM_PHASES; i++) begin
            if (p == PHASE_W'(i)) walk_latched = lat[i];
        end
    endfunction

    // State that starts service of phase p. The left advance is only offered
    // when coming from all-red, so a request made during the advance waits.
    function automatic state_e serve_state(input logic [PHASE_W-1:0]    p,
                                           input logic                  allow_left,
                                           input logic                  left_lat,
                                           input logic [NUM_PHASES-1:0] walk_lat);
        if (allow_left && (p == '0) && left_lat) begin
            serve_state = S_LEFT_ADV;
        end else if (walk_latched(walk_lat, p)) begin
            serve_state = S_WALK;
        end else begin
            serve_state = S_GREEN;
        end
    endfunction

    // ---------------- FSM ----------------
    state_e                state_q, state_d;
    logic [PHASE_W-1:0]    phase_q, phase_d;
    logic [NUM_PHASES-1:0] walk_lat_q, walk_lat_d;
    logic                  left_lat_q, left_lat_d;

    always_comb begin
        state_d  = state_q;
        phase_d  = phase_q;
        load     = 1'b0;
        load_val = '0;
        if (expire) begin
            load = 1'b1;
            case (state_q)
                S_ALL_RED: begin
                    phase_d = (phase_q == PHASE_W'(NUM_PHASES - 1)) ? '0 : phase_q + 1'b1;
                    state_d = serve_state(phase_d, 1'b1, left_lat_q, walk_lat_q);
                end
                S_LEFT_ADV: state_d = serve_state(phase_q, 1'b0, left_lat_q, walk_lat_q);
                S_GREEN:    state_d = S_AMBER;
                S_WALK:     state_d = S_FDW;
                S_FDW:      state_d = S_AMBER;
                S_AMBER:    state_d = S_ALL_RED;
                default:    state_d = S_ALL_RED;
            endcase
            load_val = duration(state_d);
        end
    end

    // Latch on any low level; the clear on service entry wins so a request
    // seen on that same cycle counts as served.
    always_comb begin
        walk_lat_d = walk_lat_q | ~walk_s2_q;
        left_lat_d = left_lat_q | ~left_s2_q;
        if ((state_d == S_WALK) && (state_q != S_WALK)) begin
            for (int i = 0; i < NUM_PHASES; i++) begin
                if (phase_d == PHASE_W'(i)) walk_lat_d[i] = 1'b0;
            end
        end
        if ((state_d == S_LEFT_ADV) && (state_q != S_LEFT_ADV)) begin
            left_lat_d = 1'b0;
        end
    end

    always_ff @(posedge clk_27 or negedge not_reset) begin
        if (!not_reset) begin
            state_q    <= S_ALL_RED;
            phase_q    <= PHASE_W'(NUM_PHASES - 1);
            walk_lat_q <= '0;
            left_lat_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            phase_q    <= phase_d;
            walk_lat_q <= walk_lat_d;
            left_lat_q <= left_lat_d;
        end
    end

    // ---------------- output decode ----------------
    // Decoded from next-state values so the registered outputs line up with
    // state_q and seconds_left on the same cycle.
    logic [LW-1:0]         lamp_q, lamp_d;
    logic [NUM_PHASES-1:0] walk_on_q, walk_on_d;
    logic [NUM_PHASES-1:0] dont_walk_q, dont_walk_d;

    always_comb begin
        lamp_d      = '0;
        walk_on_d   = '0;
        dont_walk_d = '1;
        for (int i = 0; i < NUM_PHASES; i++) begin
            if (phase_d == PHASE_W'(i)) begin
                case (state_d)
                    S_GREEN, S_WALK, S_FDW: lamp_d[LAMPS_PER_PHASE*i + LAMP_GREEN] = 1'b1;
                    S_AMBER:                lamp_d[LAMPS_PER_PHASE*i + LAMP_AMBER] = 1'b1;
                    S_LEFT_ADV: begin
                        lamp_d[LAMPS_PER_PHASE*i + LAMP_ARROW] = 1'b1;
                        lamp_d[LAMPS_PER_PHASE*i + LAMP_RED]   = 1'b1;
                    end
                    default:                lamp_d[LAMPS_PER_PHASE*i + LAMP_RED]   = 1'b1;
                endcase
                walk_on_d[i] = (state_d == S_WALK);
                if (state_d == S_FDW) dont_walk_d[i] = secs_d[0];
            end else begin
                lamp_d[LAMPS_PER_PHASE*i + LAMP_RED] = 1'b1;
            end
        end
    end

    always_ff @(posedge clk_27 or negedge not_reset) begin
        if (!not_reset) begin
            for (int i = 0; i < LW; i++) begin
                lamp_q[i] <= ((i % LAMPS_PER_PHASE) == LAMP_RED);
            end
            walk_on_q   <= '0;
            dont_walk_q <= '1;
        end else begin
            lamp_q      <= lamp_d;
            walk_on_q   <= walk_on_d;
            dont_walk_q <= dont_walk_d;
        end
    end

    assign bus.lamp                 = lamp_q;
    assign bus.walk_on              = walk_on_q;
    assign bus.dont_walk_on         = dont_walk_q;
    assign bus.active_phase         = phase_q;
    assign bus.seconds_left         = secs_q;
    assign bus.walk_request_waiting = |walk_lat_q;

endmodule
